systolic_mac_pe: RTL and testbench

Parametrised processing element for the TPU systolic array: a two-stage pipelined multiply-accumulate with operand forwarding to east/south neighbours, tile framing via `last`, and a double-buffered result register drained through a valid/ready handshake. One instance sits at each grid node. Neighbours chain through `a_out`/`b_out`/`en_out`/`last_out`, and results leave through a column drain bus.

---
 rtl/tpu_pkg.sv | 29 ++
 rtl/systolic_mac_pe_if.sv | 30 +++
 rtl/pe_mul_stage.sv | 57 +++++
 rtl/systolic_mac_pe.sv | 147 ++++++++++++++
 tb/tb_systolic_mac_pe.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array processing elements.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } pe_state_t;

  // Full-precision product width for a DATA_WIDTH x DATA_WIDTH multiply.
  function automatic int unsigned prod_width(input int unsigned dw);
    return 2 * dw;
  endfunction

  // Largest representable accumulator value (w <= 64), truncated by the caller.
  function automatic logic [63:0] sat_max(input int unsigned w, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    return is_signed ? (ones >> (65 - w)) : (ones >> (64 - w));
  endfunction

  // Smallest representable accumulator value (w <= 64), truncated by the caller.
  function automatic logic [63:0] sat_min(input int unsigned w, input bit is_signed);
    logic [63:0] ones;
    ones = '1;
    return is_signed ? ~(ones >> (65 - w)) : '0;
  endfunction

endpackage

// File: rtl/systolic_mac_pe_if.sv
// Operand, forwarding and result-drain signals of one systolic PE.
interface systolic_mac_pe_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32
) ();
  logic                  en;
  logic                  last;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a_out;
  logic [DATA_WIDTH-1:0] b_out;
  logic                  en_out;
  logic                  last_out;
  logic [ACC_WIDTH-1:0]  acc_out;
  logic                  acc_valid;
  logic                  acc_ready;
  logic                  acc_sat;
  logic                  busy;

  modport slave (
    input  en, last, a_in, b_in, acc_ready,
    output in_ready, a_out, b_out, en_out, last_out, acc_out, acc_valid, acc_sat, busy
  );

  modport master (
    output en, last, a_in, b_in, acc_ready,
    input  in_ready, a_out, b_out, en_out, last_out, acc_out, acc_valid, acc_sat, busy
  );
endinterface

// File: rtl/pe_mul_stage.sv
// Registered sign-aware multiplier (stage 1) with valid/last sideband.
module pe_mul_stage
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  accept_i,
  input  logic                  last_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  prod_o,
  output logic                  valid_o,
  output logic                  last_o
);
  localparam int unsigned PW = prod_width(DATA_WIDTH);

  logic [PW-1:0] op_a, op_b, prod_d, prod_q;
  logic          valid_q, last_q;

  // Extend operands to product width; low PW bits are exact for both signednesses.
  always_comb begin
    if (SIGNED != 0) begin
      op_a = PW'($signed(a_i));
      op_b = PW'($signed(b_i));
    end else begin
      op_a = PW'(a_i);
      op_b = PW'(b_i);
    end
    prod_d = op_a * op_b;
  end

  // Capture the product only for accepted pairs; sideband tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (accept_i) prod_q <= prod_d;
      valid_q <= accept_i;
      last_q  <= accept_i & last_i;
    end
  end

  // Widen the product to accumulator width.
  always_comb begin
    if (SIGNED != 0) prod_o = ACC_WIDTH'($signed(prod_q));
    else             prod_o = ACC_WIDTH'(prod_q);
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC processing element: 2-stage MAC, neighbour forwarding,
// tile FSM and valid/ready result buffer.
// Optional macro SYSTOLIC_PE_SATURATE_EN: saturating accumulate + acc_sat flag.
module systolic_mac_pe
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SIGNED     = 0
) (
  input  logic            clk,
  input  logic            reset,
  systolic_mac_pe_if.slave pe
);
  pe_state_t             state_q;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, acc_out_q, mul_prod;
  logic                  acc_valid_q, drained_q, mul_valid, mul_last;
  logic [DATA_WIDTH-1:0] a_out_q, b_out_q;
  logic                  en_out_q, last_out_q;
  logic                  in_ready, accept, buf_free, xfer;

  assign in_ready = (state_q != FLUSH);
  assign accept   = pe.en & in_ready;
  assign buf_free = ~acc_valid_q | pe.acc_ready;
  assign xfer     = (state_q == FLUSH) & drained_q & buf_free;

  pe_mul_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED)
  ) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .accept_i(accept),
    .last_i  (pe.last),
    .a_i     (pe.a_in),
    .b_i     (pe.b_in),
    .prod_o  (mul_prod),
    .valid_o (mul_valid),
    .last_o  (mul_last)
  );

`ifdef SYSTOLIC_PE_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED != 0));
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED != 0));

  logic [ACC_WIDTH:0] sum_w;
  logic               sat_d, sat_q, acc_sat_q;

  // Stage-2 sum with one guard bit; clamp on overflow and flag it.
  always_comb begin
    sat_d = 1'b0;
    if (SIGNED != 0) sum_w = {acc_q[ACC_WIDTH-1], acc_q} + {mul_prod[ACC_WIDTH-1], mul_prod};
    else             sum_w = {1'b0, acc_q} + {1'b0, mul_prod};
    acc_d = sum_w[ACC_WIDTH-1:0];
    if (SIGNED != 0) begin
      if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
        sat_d = 1'b1;
        acc_d = sum_w[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
      end
    end else if (sum_w[ACC_WIDTH]) begin
      sat_d = 1'b1;
      acc_d = SAT_MAX;
    end
  end

  // Sticky per-tile saturation flag, handed to the result buffer at transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q     <= 1'b0;
      acc_sat_q <= 1'b0;
    end else if (xfer) begin
      sat_q     <= 1'b0;
      acc_sat_q <= sat_q;
    end else if (mul_valid) begin
      sat_q <= sat_q | sat_d;
    end
  end

  assign pe.acc_sat = acc_sat_q;
`else
  // Stage-2 sum, wrapping modulo 2^ACC_WIDTH.
  always_comb begin
    acc_d = acc_q + mul_prod;
  end

  assign pe.acc_sat = 1'b0;
`endif

  // Accumulator: add each product, clear when the tile result is transferred.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         acc_q <= '0;
    else if (xfer)      acc_q <= '0;
    else if (mul_valid) acc_q <= acc_d;
  end

  // Tile FSM and result buffer. drained_q marks that the tile's last product
  // has been accumulated, so FLUSH only transfers a complete sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      drained_q   <= 1'b0;
    end else begin
      if (mul_last) drained_q <= 1'b1;
      if (acc_valid_q && pe.acc_ready) acc_valid_q <= 1'b0;
      case (state_q)
        IDLE:    if (accept) state_q <= pe.last ? FLUSH : ACCUM;
        ACCUM:   if (accept && pe.last) state_q <= FLUSH;
        FLUSH: begin
          if (xfer) begin
            acc_out_q   <= acc_q;
            acc_valid_q <= 1'b1;
            drained_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Neighbour forwarding, every cycle regardless of state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out_q    <= '0;
      b_out_q    <= '0;
      en_out_q   <= 1'b0;
      last_out_q <= 1'b0;
    end else begin
      a_out_q    <= pe.a_in;
      b_out_q    <= pe.b_in;
      en_out_q   <= accept;
      last_out_q <= accept & pe.last;
    end
  end

  assign pe.in_ready  = in_ready;
  assign pe.a_out     = a_out_q;
  assign pe.b_out     = b_out_q;
  assign pe.en_out    = en_out_q;
  assign pe.last_out  = last_out_q;
  assign pe.acc_out   = acc_out_q;
  assign pe.acc_valid = acc_valid_q;
  assign pe.busy      = (state_q != IDLE) | acc_valid_q;
endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed bench: three PEs (unsigned/32, signed/32, unsigned/16) share stimulus.
module tb_systolic_mac_pe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, last, acc_ready;
  logic [7:0] a, b;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  systolic_mac_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(32)) if0 ();
  systolic_mac_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(32)) if1 ();
  systolic_mac_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) if2 ();

  assign if0.en = en;  assign if0.last = last;  assign if0.a_in = a;  assign if0.b_in = b;  assign if0.acc_ready = acc_ready;
  assign if1.en = en;  assign if1.last = last;  assign if1.a_in = a;  assign if1.b_in = b;  assign if1.acc_ready = acc_ready;
  assign if2.en = en;  assign if2.last = last;  assign if2.a_in = a;  assign if2.b_in = b;  assign if2.acc_ready = acc_ready;

  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(0)) u0 (.clk(clk), .reset(rst_n), .pe(if0));
  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SIGNED(1)) u1 (.clk(clk), .reset(rst_n), .pe(if1));
  systolic_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .SIGNED(0)) u2 (.clk(clk), .reset(rst_n), .pe(if2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ai, input logic [7:0] bi, input logic li);
    a = ai; b = bi; last = li; en = 1'b1;
    tick();
    en = 1'b0; last = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; last = 1'b0; a = '0; b = '0; acc_ready = 1'b1;
    #2;
    check("rst_in_ready",  32'(if0.in_ready), 32'd1);
    check("rst_busy",      32'(if0.busy), 32'd0);
    check("rst_acc_valid", 32'(if0.acc_valid), 32'd0);
    check("rst_acc_out",   32'(if0.acc_out), 32'd0);
    check("rst_acc_sat",   32'(if0.acc_sat), 32'd0);
    check("rst_a_out",     32'(if0.a_out), 32'd0);
    check("rst_en_out",    32'(if0.en_out), 32'd0);
    check("rst_last_out",  32'(if0.last_out), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Forwarding; a single-pair tile with en held through FLUSH.
    a = 8'hA5; b = 8'h3C; en = 1'b1; last = 1'b1;
    tick();
    check("fwd_a_out",    32'(if0.a_out), 32'hA5);
    check("fwd_b_out",    32'(if0.b_out), 32'h3C);
    check("fwd_en_out",   32'(if0.en_out), 32'd1);
    check("fwd_last_out", 32'(if0.last_out), 32'd1);
    check("fwd_in_ready", 32'(if0.in_ready), 32'd0);
    a = 8'h11; b = 8'h22;
    tick();
    check("fwd_flush_en_out",   32'(if0.en_out), 32'd0);
    check("fwd_flush_last_out", 32'(if0.last_out), 32'd0);
    check("fwd_flush_a_out",    32'(if0.a_out), 32'h11);
    en = 1'b0; last = 1'b0;
    tick();
    check("fwd_u0_acc", 32'(if0.acc_out), 32'd9900);
    check("fwd_u1_acc", 32'(if1.acc_out), 32'hFFFF_EAAC);
    check("fwd_u2_acc", 32'(if2.acc_out), 32'd9900);
    tick();

    // Unsigned tile (3,4),(5,6),(2,10,last) -> 62.
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd2, 8'd10, 1'b1);
    tick();
    check("t1_valid_e1", 32'(if0.acc_valid), 32'd0);
    check("t1_in_ready_flush", 32'(if0.in_ready), 32'd0);
    check("t1_busy_flush", 32'(if0.busy), 32'd1);
    tick();
    check("t1_valid_e2", 32'(if0.acc_valid), 32'd1);
    check("t1_acc_out",  32'(if0.acc_out), 32'd62);
    check("t1_acc_sat",  32'(if0.acc_sat), 32'd0);
    check("t1_in_ready_idle", 32'(if0.in_ready), 32'd1);
    tick();
    check("t1_valid_drop", 32'(if0.acc_valid), 32'd0);
    check("t1_busy_idle",  32'(if0.busy), 32'd0);

    // Signed tile (-3,4),(-2,-5,last).
    send(8'hFD, 8'd4, 1'b0);
    send(8'hFE, 8'hFB, 1'b1);
    tick(); tick();
    check("t2_u1_signed", 32'(if1.acc_out), 32'hFFFF_FFFE);
    check("t2_u0_unsigned", 32'(if0.acc_out), 32'd64766);
    check("t2_u2_unsigned", 32'(if2.acc_out), 32'd64766);
    tick();

    // Backpressure.
    acc_ready = 1'b0;
    send(8'd1, 8'd1, 1'b1);
    tick(); tick();
    check("bp_t1_valid", 32'(if0.acc_valid), 32'd1);
    check("bp_t1_out",   32'(if0.acc_out), 32'd1);
    send(8'd2, 8'd3, 1'b1);
    tick(); tick(); tick();
    check("bp_hold_in_ready", 32'(if0.in_ready), 32'd0);
    check("bp_hold_out",      32'(if0.acc_out), 32'd1);
    check("bp_hold_valid",    32'(if0.acc_valid), 32'd1);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check("bp_swap_out",   32'(if0.acc_out), 32'd6);
    check("bp_swap_valid", 32'(if0.acc_valid), 32'd1);
    check("bp_swap_in_ready", 32'(if0.in_ready), 32'd1);
    check("bp_swap_u2_out", 32'(if2.acc_out), 32'd6);
    acc_ready = 1'b1;
    tick();
    check("bp_drain_valid", 32'(if0.acc_valid), 32'd0);

    // Overflow on the 16-bit accumulator.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    tick(); tick();
`ifdef SYSTOLIC_PE_SATURATE_EN
    check("ovf_u2_acc", 32'(if2.acc_out), 32'd65535);
    check("ovf_u2_sat", 32'(if2.acc_sat), 32'd1);
`else
    check("ovf_u2_acc", 32'(if2.acc_out), 32'd64514);
    check("ovf_u2_sat", 32'(if2.acc_sat), 32'd0);
`endif
    check("ovf_u0_acc", 32'(if0.acc_out), 32'h0001_FC02);
    check("ovf_u0_sat", 32'(if0.acc_sat), 32'd0);
    check("ovf_u1_acc", 32'(if1.acc_out), 32'd2);
    tick();

    // Reset mid-tile discards the partial sum.
    send(8'd7, 8'd7, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready",  32'(if0.in_ready), 32'd1);
    check("mrst_busy",      32'(if0.busy), 32'd0);
    check("mrst_acc_valid", 32'(if0.acc_valid), 32'd0);
    check("mrst_acc_out",   32'(if0.acc_out), 32'd0);
    check("mrst_a_out",     32'(if0.a_out), 32'd0);
    check("mrst_en_out",    32'(if0.en_out), 32'd0);
    check("mrst_u2_sat",    32'(if2.acc_sat), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'd2, 8'd2, 1'b1);
    tick(); tick();
    check("mrst_after_out",   32'(if0.acc_out), 32'd4);
    check("mrst_after_valid", 32'(if0.acc_valid), 32'd1);
    check("mrst_after_u1",    32'(if1.acc_out), 32'd4);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
